arb4_rr: RTL
============

# arb4_rr

Four-requester round-robin arbiter that owns the select lines of the `mux4way` datapath. It grants one requester at a time. While a grant is held it drives the 2-bit select so the granted input is the one routed through the mux. It sits between four independent sources and one shared 4:1 mux, giving each source fair, non-starving access.

## Interface
Parameters:
- `BURST_MAX`, default 8: maximum consecutive grant cycles per owner when the burst limit is compiled in. Legal range 2..255.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high; sampled on the `clk` rising edge.
- `req`, in, 4: request per source. Bit n is source n. A source holds its bit high for as long as it needs the mux.
- `gnt`, out, 4: one-hot grant, or all zero when idle. Registered.
- `sel`, out, 2: binary index of the current owner. Drives the mux select pair, with `sel[0]` as the low-order select and `sel[1]` as the high-order select. Registered.
- `busy`, out, 1: high when any `gnt` bit is set. Registered.

## Operation
- State: `IDLE` or `OWN`, plus:
  - 2-bit priority pointer `ptr`;
  - 2-bit owner index;
  - burst counter, ceil(log2(BURST_MAX)) bits.
- Reset values: `gnt`=0000, `sel`=00, `busy`=0, `ptr`=0, counter=0, state `IDLE`.
- Winner selection: the first set bit of `req`, scanning cyclically ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If `req` is nonzero, grant the winner at the next edge and enter `OWN`.
  - Counter is set to 0 and `sel` is set to the winner's index.
  - If `req` is zero, stay `IDLE`.
- OWN, while `req[owner]`=1: hold the grant and increment the counter (saturating).
- OWN, release (`req[owner]`=0 sampled at an edge):
  - Set `ptr` to owner+1 (mod 4).
  - If any other `req` bit is set, grant passes directly to the next winner, computed with the new `ptr`, at that same edge. There is no idle bubble.
  - Otherwise `gnt` goes to 0000 and the state goes to `IDLE`.
- `sel` holds the last owner's index while `IDLE`, so the mux output stays stable.
- Simultaneous events:
  - Owner release and a new request from another source in the same cycle: the new requester is granted at that edge.
  - A request from the owner itself re-raised in the same cycle it dropped is treated as a release, because the drop was sampled.
- Reset mid-grant: at the next edge all outputs return to their reset values and `ptr` returns to 0. There is no partial handover.
- Invariant: at most one `gnt` bit is set, and `sel` equals the index of the set bit whenever `busy`=1.

## Timing
- Request to grant: 1 cycle from an `IDLE` state (request sampled at edge k, `gnt` valid after edge k).
- Release to handover: 0 bubble cycles. The new `gnt` is valid after the edge that samples the release.
- All outputs are registered. There is no combinational path from `req` to `gnt`, `sel` or `busy`.
- Worst-case wait for a continuously asserted request:
  - with the burst limit: 3 × BURST_MAX cycles plus 1;
  - without it: unbounded (it depends on owners releasing).

## Configuration
- `ARB4_BURST_LIMIT_EN` defined (burst limit compiled in):
  - When the counter reaches BURST_MAX−1 and any other `req` bit is set, the grant rotates at the next edge as if the owner had released, and `ptr` becomes owner+1.
  - If no other requester is pending, the owner keeps the grant and the counter saturates.
- `ARB4_BURST_LIMIT_EN` not defined:
  - The counter logic is absent.
  - The owner keeps the grant until it drops `req`.

## Test plan
- Reset then single request: `rst`=1 for 2 cycles, then `req`=0100 → one cycle later `gnt`=0100, `sel`=10, `busy`=1. Drop `req` → next edge `gnt`=0000, `busy`=0, `sel` stays 10.
- Fair rotation: `req`=1111, each owner drops its bit for one cycle after 3 cycles then re-raises it → grant order 0,1,2,3,0. Handover has no cycle with `gnt`=0000.
- Pointer wrap: with `ptr`=3, `req`=1001 → grant goes to source 3; after its release it goes to source 0.
- Burst limit (macro defined, BURST_MAX=4): `req`=0011 held constant → `gnt` alternates 0001 for 4 cycles, then 0010 for 4 cycles. With only `req`=0001 held, `gnt` stays 0001 indefinitely.
- No burst limit (macro undefined): `req`=0011 held for 50 cycles → `gnt` stays 0001 throughout.
- Reset mid-grant: `gnt`=0010 with `ptr`=2, then assert `rst` one cycle → `gnt`=0000, `sel`=00, `busy`=0. With `req`=1111 afterward, the first grant is 0001.

Source files
------------

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter driving the select pair of a shared 4:1 mux.
// Define ARB4_BURST_LIMIT_EN to cap consecutive grant cycles per owner at BURST_MAX.
module arb4_rr #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0] state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n;
  logic       busy_n;
  logic [3:0] others_c;
  logic [1:0] win_c;
  logic       handover_c;

`ifdef ARB4_BURST_LIMIT_EN
  localparam int unsigned CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  // First set bit of r scanning cyclically from p.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {r, r};
    rot = dbl[p +: 4];
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    return p + off;
  endfunction

  // sel doubles as the owner index while in OWN.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    gnt_n      = gnt;
    sel_n      = sel;
    busy_n     = busy;
    handover_c = 1'b0;
    win_c      = 2'd0;
    others_c   = req & ~gnt;
`ifdef ARB4_BURST_LIMIT_EN
    cnt_n      = cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          win_c   = pick(req, ptr);
          state_n = OWN;
          gnt_n   = 4'b0001 << win_c;
          sel_n   = win_c;
          busy_n  = 1'b1;
`ifdef ARB4_BURST_LIMIT_EN
          cnt_n   = '0;
`endif
        end
      end
      default: begin
        handover_c = ~req[sel];
`ifdef ARB4_BURST_LIMIT_EN
        if ((cnt == CNT_LAST) && (|others_c)) handover_c = 1'b1;
`endif
        if (handover_c) begin
          ptr_n = sel + 2'd1;
          if (|others_c) begin
            win_c = pick(others_c, sel + 2'd1);
            gnt_n = 4'b0001 << win_c;
            sel_n = win_c;
`ifdef ARB4_BURST_LIMIT_EN
            cnt_n = '0;
`endif
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            busy_n  = 1'b0;
          end
        end else begin
`ifdef ARB4_BURST_LIMIT_EN
          if (cnt != CNT_LAST) cnt_n = cnt + CW'(1);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      busy  <= 1'b0;
`ifdef ARB4_BURST_LIMIT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      busy  <= busy_n;
`ifdef ARB4_BURST_LIMIT_EN
      cnt   <= cnt_n;
`endif
    end
  end

endmodule
